// File: rtl/axis_cmult_array.sv
// axis_cmult_array: multi-channel complex weight multiplier for AXI-Stream.
// Each beat carries CHANNELS x SAMPLES complex samples (real plane low,
// imag plane high). Every sample is multiplied by its channel's complex
// weight in a three-stage pipeline with a single global advance enable.
// Weight changes are staged and only applied at the first beat of a frame.
module axis_cmult_array #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SAMPLES      = 8,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned WEIGHT_FRAC  = 7,
    parameter bit          SATURATE     = 1'b1,
    parameter int unsigned LANE_W       = CHANNELS * SAMPLES * SAMPLE_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CHANNELS*WEIGHT_WIDTH-1:0] weight_re,
    input  logic [CHANNELS*WEIGHT_WIDTH-1:0] weight_im,
    input  logic                             weight_update,
    input  logic [2*LANE_W-1:0]              s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [2*LANE_W-1:0]              m_axis_tdata,
    output logic [2*LANE_W/8-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             sat_event,
    output logic [15:0]                      sat_count
);

    localparam int unsigned LANES  = CHANNELS * SAMPLES;
    localparam int unsigned DW     = 2 * LANE_W;
    localparam int unsigned KEEP_W = DW / 8;
    localparam int unsigned CW     = CHANNELS * WEIGHT_WIDTH;
    localparam int unsigned PW     = SAMPLE_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SW1    = PW + 1;

    localparam logic signed [SW1-1:0] RND  = SW1'(1 << (WEIGHT_FRAC - 1));
    localparam logic signed [SW1-1:0] MAXV = SW1'((1 << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [SW1-1:0] MINV = ~MAXV;

    // Global pipeline advance and input handshake
    logic w_en;
    logic w_accept;
    assign w_en          = !r_m_valid || m_axis_tready;
    assign s_axis_tready = w_en && !reset;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // Weight staging state
    logic [CW-1:0] r_pend_re;
    logic [CW-1:0] r_pend_im;
    logic          r_pend_flag;
    logic [CW-1:0] r_act_re;
    logic [CW-1:0] r_act_im;
    logic          r_in_frame;
    logic [CW-1:0] w_use_re;
    logic [CW-1:0] w_use_im;

    // Pipeline registers
    logic [DW-1:0] r_s1_data;
    logic [CW-1:0] r_s1_wre;
    logic [CW-1:0] r_s1_wim;
    logic          r_s1_valid;
    logic          r_s1_last;
    logic          r_s2_valid;
    logic          r_s2_last;
    logic [DW-1:0] r_m_data;
    logic [KEEP_W-1:0] r_m_keep;
    logic          r_m_valid;
    logic          r_m_last;
    logic          r_m_sat;
    logic [15:0]   r_sat_count;

    logic [DW-1:0]    w_q_data;
    logic [LANES-1:0] w_lane_sat;

    // Weight seen by a beat: a frame-first beat picks up any staged weight
    assign w_use_re = (!r_in_frame && r_pend_flag) ? r_pend_re : r_act_re;
    assign w_use_im = (!r_in_frame && r_pend_flag) ? r_pend_im : r_act_im;

    // Pending/active weight registers and frame tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_re   <= '0;
            r_pend_im   <= '0;
            r_pend_flag <= 1'b0;
            r_act_re    <= '0;
            r_act_im    <= '0;
            r_in_frame  <= 1'b0;
        end else begin
            if (w_accept && !r_in_frame) begin
                r_act_re    <= w_use_re;
                r_act_im    <= w_use_im;
                r_pend_flag <= 1'b0;
            end
            if (weight_update) begin
                r_pend_re   <= weight_re;
                r_pend_im   <= weight_im;
                r_pend_flag <= 1'b1;
            end
            if (w_accept) begin
                r_in_frame <= !s_axis_tlast;
            end
        end
    end

    // S1: register input beat with the weight it must use
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_data  <= '0;
            r_s1_wre   <= '0;
            r_s1_wim   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_data  <= s_axis_tdata;
            r_s1_wre   <= w_use_re;
            r_s1_wim   <= w_use_im;
            r_s1_valid <= s_axis_tvalid;
            r_s1_last  <= s_axis_tlast;
        end
    end

    // S2 control: valid/last follow the products
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            localparam int unsigned CH = l / SAMPLES;

            logic signed [SAMPLE_WIDTH-1:0] w_xr;
            logic signed [SAMPLE_WIDTH-1:0] w_xi;
            logic signed [WEIGHT_WIDTH-1:0] w_wr;
            logic signed [WEIGHT_WIDTH-1:0] w_wi;
            logic signed [PW-1:0]           r_rr;
            logic signed [PW-1:0]           r_ii;
            logic signed [PW-1:0]           r_ri;
            logic signed [PW-1:0]           r_ir;
            logic signed [SW1-1:0]          w_sum_re;
            logic signed [SW1-1:0]          w_sum_im;
            logic signed [SW1-1:0]          w_shr_re;
            logic signed [SW1-1:0]          w_shr_im;
            logic [SAMPLE_WIDTH-1:0]        w_q_re;
            logic [SAMPLE_WIDTH-1:0]        w_q_im;
            logic                           w_sat;

            assign w_xr = r_s1_data[l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            assign w_xi = r_s1_data[LANE_W + l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            assign w_wr = r_s1_wre[CH*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign w_wi = r_s1_wim[CH*WEIGHT_WIDTH +: WEIGHT_WIDTH];

            // S2: four partial products of the complex multiply
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_rr <= '0;
                    r_ii <= '0;
                    r_ri <= '0;
                    r_ir <= '0;
                end else if (w_en) begin
                    r_rr <= PW'(w_xr) * PW'(w_wr);
                    r_ii <= PW'(w_xi) * PW'(w_wi);
                    r_ri <= PW'(w_xr) * PW'(w_wi);
                    r_ir <= PW'(w_xi) * PW'(w_wr);
                end
            end

            // S3 datapath: combine, round half up, then clamp or wrap
            always_comb begin
                w_sum_re = SW1'(r_rr) - SW1'(r_ii);
                w_sum_im = SW1'(r_ri) + SW1'(r_ir);
                w_shr_re = (w_sum_re + RND) >>> WEIGHT_FRAC;
                w_shr_im = (w_sum_im + RND) >>> WEIGHT_FRAC;
                w_q_re   = w_shr_re[SAMPLE_WIDTH-1:0];
                w_q_im   = w_shr_im[SAMPLE_WIDTH-1:0];
                w_sat    = 1'b0;
                if (SATURATE) begin
                    if (w_shr_re > MAXV) begin
                        w_q_re = MAXV[SAMPLE_WIDTH-1:0];
                        w_sat  = 1'b1;
                    end else if (w_shr_re < MINV) begin
                        w_q_re = MINV[SAMPLE_WIDTH-1:0];
                        w_sat  = 1'b1;
                    end
                    if (w_shr_im > MAXV) begin
                        w_q_im = MAXV[SAMPLE_WIDTH-1:0];
                        w_sat  = 1'b1;
                    end else if (w_shr_im < MINV) begin
                        w_q_im = MINV[SAMPLE_WIDTH-1:0];
                        w_sat  = 1'b1;
                    end
                end
            end

            assign w_q_data[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]          = w_q_re;
            assign w_q_data[LANE_W + l*SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_q_im;
            assign w_lane_sat[l]                                     = w_sat;
        end
    endgenerate

    // S3: output register; data and keep are forced to zero on bubbles
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_sat   <= 1'b0;
        end else if (w_en) begin
            r_m_data  <= r_s2_valid ? w_q_data : '0;
            r_m_keep  <= {KEEP_W{r_s2_valid}};
            r_m_valid <= r_s2_valid;
            r_m_last  <= r_s2_valid && r_s2_last;
            r_m_sat   <= r_s2_valid && (|w_lane_sat);
        end
    end

    // Saturated-beat counter, counts on handshake and sticks at all ones
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if (r_m_valid && m_axis_tready && r_m_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign sat_event     = r_m_sat;
    assign sat_count     = r_sat_count;

endmodule

// File: tb/tb_axis_cmult_array.sv
// Bench for axis_cmult_array: a saturating and a wrapping instance share the
// same stimulus; expected beats are queued at acceptance and checked by a
// monitor whenever an output handshake occurs.
module tb_axis_cmult_array;

    localparam int unsigned CH     = 2;
    localparam int unsigned SM     = 8;
    localparam int unsigned SW     = 16;
    localparam int unsigned WW     = 8;
    localparam int unsigned LANES  = CH * SM;
    localparam int unsigned LANE_W = LANES * SW;
    localparam int unsigned DW     = 2 * LANE_W;
    localparam int unsigned KW     = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d_sat;
        logic [DW-1:0] d_wrap;
        logic          last;
        logic          sat;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CH*WW-1:0]  weight_re = '0;
    logic [CH*WW-1:0]  weight_im = '0;
    logic              weight_update = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic              m_tready = 1'b1;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              sat_event;
    logic [15:0]       sat_count;
    logic              x_s_tready;
    logic [DW-1:0]     x_tdata;
    logic [KW-1:0]     x_tkeep;
    logic              x_tvalid;
    logic              x_tlast;
    logic              x_sat_event;
    logic [15:0]       x_sat_count;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   sat_exp  = 0;
    int   rdy_mode = 0;
    int   rdy_cyc  = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    axis_cmult_array #(.SATURATE(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .weight_re(weight_re), .weight_im(weight_im), .weight_update(weight_update),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .sat_event(sat_event), .sat_count(sat_count)
    );

    axis_cmult_array #(.SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset(reset),
        .weight_re(weight_re), .weight_im(weight_im), .weight_update(weight_update),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(x_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(x_tdata), .m_axis_tkeep(x_tkeep), .m_axis_tvalid(x_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(x_tlast),
        .sat_event(x_sat_event), .sat_count(x_sat_count)
    );

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Beat with the same complex value in every lane of both channels
    function automatic logic [DW-1:0] uni(input int r, input int i);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            d[k*SW +: SW]          = SW'(r);
            d[LANE_W + k*SW +: SW] = SW'(i);
        end
        return d;
    endfunction

    function automatic exp_t mk(input int er, input int ei, input int wer, input int wei,
                                input logic last, input logic sat);
        exp_t e;
        e.d_sat  = uni(er, ei);
        e.d_wrap = uni(wer, wei);
        e.last   = last;
        e.sat    = sat;
        return e;
    endfunction

    // Q1.7 rounding: floor((p + 64) / 128)
    function automatic int rshift(input longint p);
        return int'((p + 64) >>> 7);
    endfunction

    // Output ready pattern: 0 = always ready, 1 = never, 2 = pseudo-random with a 5-cycle hold
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            default: begin
                rdy_cyc++;
                if (rdy_cyc >= 8 && rdy_cyc < 13) m_tready = 1'b0;
                else m_tready = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // Monitor: compare every output handshake against the scoreboard head
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h with no beat pending", m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("data_sat", m_tdata, e.d_sat);
                    check("data_wrap", x_tdata, e.d_wrap);
                    check("wrap_valid", DW'(x_tvalid), DW'(1'b1));
                    check("tkeep", DW'(m_tkeep), DW'({KW{1'b1}}));
                    check("tlast", DW'(m_tlast), DW'(e.last));
                    check("sat_event", DW'(sat_event), DW'(e.sat));
                    check("wrap_sat_event", DW'(x_sat_event), DW'(1'b0));
                end
            end else if (m_tvalid) begin
                check("stall_tready", DW'(s_tready), DW'(1'b0));
            end else begin
                check("idle_data", m_tdata, '0);
                check("idle_keep", DW'(m_tkeep), '0);
            end
        end
    end

    task automatic wset(input int wr, input int wi);
        weight_re     = {CH{WW'(wr)}};
        weight_im     = {CH{WW'(wi)}};
        weight_update = 1'b1;
        @(posedge clock); #1;
        weight_update = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input exp_t e, input bit upd);
        bit acc;
        acc = 1'b0;
        s_tdata       = d;
        s_tlast       = last;
        s_tvalid      = 1'b1;
        weight_update = upd;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clock);
            if (s_tready) begin
                sb.push_back(e);
                if (e.sat) sat_exp++;
                acc = 1'b1;
            end
            @(posedge clock); #1;
            weight_update = 1'b0;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: s_axis_tready stayed 0, required 1");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(posedge clock); #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        exp_t          e;
        int            xr, xi;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_tvalid", DW'(m_tvalid), '0);
        check("rst_tdata", m_tdata, '0);
        check("rst_tkeep", DW'(m_tkeep), '0);
        check("rst_tlast", DW'(m_tlast), '0);
        check("rst_sat_count", DW'(sat_count), '0);
        check("rst_s_tready", DW'(s_tready), '0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Real scaling by 0.5
        wset(64, 0);
        send(uni(1000, 0), 1'b1, mk(500, 0, 500, 0, 1'b1, 1'b0), 1'b0);

        // Complex multiply by (0.5 + 0.5j)
        wset(64, 64);
        send(uni(100, 200), 1'b1, mk(-50, 150, -50, 150, 1'b1, 1'b0), 1'b0);

        // Rounding half toward +inf
        wset(64, 0);
        send(uni(3, 0), 1'b1, mk(2, 0, 2, 0, 1'b1, 1'b0), 1'b0);
        send(uni(-3, 0), 1'b1, mk(-1, 0, -1, 0, 1'b1, 1'b0), 1'b0);

        // Saturation: (-32768)*(-1.0) overflows; wrap instance keeps LSBs
        wset(-128, 0);
        send(uni(-32768, -32768), 1'b1,
             mk(32767, 32767, -32768, -32768, 1'b1, 1'b1), 1'b0);
        drain();
        check("sat_count_one", DW'(sat_count), DW'(sat_exp));
        check("wrap_sat_count", DW'(x_sat_count), '0);

        // Mid-frame update only takes effect at the next frame
        wset(64, 0);
        send(uni(1000, 0), 1'b0, mk(500, 0, 500, 0, 1'b0, 1'b0), 1'b0);
        wset(32, 0);
        send(uni(1000, 0), 1'b0, mk(500, 0, 500, 0, 1'b0, 1'b0), 1'b0);
        send(uni(1000, 0), 1'b1, mk(500, 0, 500, 0, 1'b1, 1'b0), 1'b0);
        send(uni(1000, 0), 1'b1, mk(250, 0, 250, 0, 1'b1, 1'b0), 1'b0);

        // Update coincident with a frame-first beat: beat uses the older pending value
        wset(64, 0);
        weight_re = {CH{WW'(32)}};
        weight_im = '0;
        send(uni(1000, 0), 1'b1, mk(500, 0, 500, 0, 1'b1, 1'b0), 1'b1);
        send(uni(1000, 0), 1'b1, mk(250, 0, 250, 0, 1'b1, 1'b0), 1'b0);
        drain();

        // 20-beat ramp frame under random backpressure
        wset(100, -30);
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            d = '0;
            e.d_sat = '0;
            for (int l = 0; l < LANES; l++) begin
                xr = 200 * k + 7 * l - 1500;
                xi = 3000 - 150 * k + 5 * l;
                d[l*SW +: SW]                = SW'(xr);
                d[LANE_W + l*SW +: SW]       = SW'(xi);
                e.d_sat[l*SW +: SW]          = SW'(rshift(longint'(xr) * 100 - longint'(xi) * (-30)));
                e.d_sat[LANE_W + l*SW +: SW] = SW'(rshift(longint'(xr) * (-30) + longint'(xi) * 100));
            end
            e.d_wrap = e.d_sat;
            e.last   = (k == 19);
            e.sat    = 1'b0;
            send(d, (k == 19), e, 1'b0);
        end
        drain();
        rdy_mode = 0;
        @(posedge clock); #1;

        // Reset with three beats in flight
        rdy_mode = 1;
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            send(uni(1000, 0), 1'b1, mk(0, 0, 0, 0, 1'b1, 1'b0), 1'b0);
        end
        reset = 1'b1;
        sb.delete();
        sat_exp = 0;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_tvalid", DW'(m_tvalid), '0);
        check("mid_rst_tdata", m_tdata, '0);
        check("mid_rst_tkeep", DW'(m_tkeep), '0);
        check("mid_rst_tlast", DW'(m_tlast), '0);
        check("mid_rst_sat_event", DW'(sat_event), '0);
        check("mid_rst_sat_count", DW'(sat_count), '0);
        @(posedge clock); #1;
        reset    = 1'b0;
        rdy_mode = 0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("no_residual", DW'(m_tvalid), '0);
        @(posedge clock); #1;

        // Weights were cleared by reset, so output is zero
        send(uni(1000, 0), 1'b1, mk(0, 0, 0, 0, 1'b1, 1'b0), 1'b0);
        wset(64, 0);
        send(uni(-2000, 400), 1'b1, mk(-1000, 200, -1000, 200, 1'b1, 1'b0), 1'b0);
        drain();
        check("final_sat_count", DW'(sat_count), DW'(sat_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
